pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush controller for the five-stage pipeline. It produces the freeze and flush controls consumed by the F/D/E/M pipeline registers and selects the next-PC source for exception entry and eret. It also owns the multi-cycle mult/div occupancy counter. It sits beside the D-stage decoder and takes hazard metadata from the D, E and M stages.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start
DIV_CYCLES, 10, busy cycles after a div/divu start

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-low; 0 = reset at the next posedge
d_rs  in  5  D-stage rs index
d_rt  in  5  D-stage rt index
d_rs_tuse  in  2  cycles until D needs rs (3 = unused)
d_rt_tuse  in  2  cycles until D needs rt (3 = unused)
d_is_md  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
e_wa  in  5  E-stage dest reg
e_tnew  in  2  cycles until E result is ready
m_wa  in  5  M-stage dest reg
m_tnew  in  2  cycles until M result is ready
e_md_start  in  2  00 none, 01 mult, 10 div, 11 reserved (treated as none)
m_exc_req  in  1  exception/interrupt taken at M
m_eret  in  1  eret at M
freeze_f  out  1  hold PC
freeze_d  out  1  hold D register
flush_d  out  1  clear D register
flush_e  out  1  load bubble into E register
flush_m  out  1  clear M register
pc_sel  out  2  00 sequential/branch, 01 handler 0x00004180, 10 EPC
md_busy  out  1  mult/div unit occupied
md_done  out  1  last busy cycle; HI/LO written at the end of this cycle

Behaviour:
- Reset (reset==0 at posedge): cnt<=0 and md state <= IDLE. While reset is low, all outputs are 0.
- Register hazard, combinational:
  - hz_rs = (d_rs!=0) & ((d_rs==e_wa & d_rs_tuse<e_tnew) | (d_rs==m_wa & d_rs_tuse<m_tnew)).
  - hz_rt is the same expression using rt.
- MD hazard: hz_md = d_is_md & (md_busy | e_md_start∈{01,10}).
- stall = hz_rs | hz_rt | hz_md.
- Priority, per cycle, combinational outputs:
  1. m_exc_req: flush_d=flush_e=flush_m=1, freeze_*=0, pc_sel=01. Wins over m_eret in the same cycle.
  2. m_eret: flush_d=flush_e=flush_m=1, freeze_*=0, pc_sel=10.
  3. stall: freeze_f=freeze_d=flush_e=1, flush_d=flush_m=0, pc_sel=00.
  4. Otherwise all controls are 0 and pc_sel=00.
- MD FSM states: IDLE, MULT, DIV. 6-bit down counter cnt.
  - IDLE, valid start in cycle t, and neither m_exc_req nor m_eret in cycle t: cnt<=MULT_CYCLES or DIV_CYCLES and the state moves to MULT or DIV at the edge ending t.
  - A start coincident with m_exc_req/m_eret is ignored, because the E instr is being flushed.
  - MULT/DIV: cnt decrements every cycle. md_busy = (cnt!=0). md_done = (cnt==1). When cnt reaches 0, return to IDLE.
  - A start is therefore busy for exactly N cycles (t+1..t+N), with md_done at t+N.
  - Exceptions do not abort an in-flight op; the counter keeps running.
  - A start while busy is illegal (prevented by hz_md). The RTL ignores it and keeps the current cnt.
- Reset mid-operation: cnt is cleared immediately at the edge, and md_busy and md_done are 0 in the next cycle.
- No state other than cnt and the md state; all stall and flush outputs are purely combinational from inputs and state.

Test Plan:
1. Load-use: d_rs=5, d_rs_tuse=0, e_wa=5, e_tnew=2 -> freeze_f=freeze_d=flush_e=1. With e_wa=0 instead -> no stall.
2. Mult occupancy: e_md_start=01 at cycle t with no exception -> md_busy=1 for t+1..t+5, md_done=1 only at t+5, md_busy=0 at t+6. With d_is_md=1 throughout -> stall at t..t+5, released at t+6.
3. Div with DIV_CYCLES=10 -> md_busy for exactly 10 cycles. A second start injected mid-op does not change cnt.
4. Priority: m_exc_req=1, m_eret=1 and hz_rs active together -> pc_sel=01, flush_d/e/m=1, freeze_f=0. Drop m_exc_req -> pc_sel=10.
5. Start coincident with m_exc_req -> md_busy stays 0. An exception during a busy div -> counter continues to md_done.
6. Reset driven low at cnt=3 -> all outputs 0 while low. After release, md_busy=0 and a new mult start counts the full 5 cycles.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: register and mult/div hazards,
// exception/eret redirection, and the mult/div occupancy counter.
module pipe_hazard_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_rs_tuse,
    input  logic [1:0] d_rt_tuse,
    input  logic       d_is_md,
    input  logic [4:0] e_wa,
    input  logic [1:0] e_tnew,
    input  logic [4:0] m_wa,
    input  logic [1:0] m_tnew,
    input  logic [1:0] e_md_start,
    input  logic       m_exc_req,
    input  logic       m_eret,
    output logic       freeze_f,
    output logic       freeze_d,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic [1:0] pc_sel,
    output logic       md_busy,
    output logic       md_done
);

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

    md_state_t  state_reg, state_next;
    logic [5:0] cnt_reg, cnt_next;

    logic [4:0] src [2];
    logic [1:0] tuse [2];
    logic [1:0] hz_reg_src;
    logic       start_valid;
    logic       busy_int;
    logic       done_int;
    logic       hz_md;
    logic       stall;

    assign src[0]  = d_rs;
    assign src[1]  = d_rt;
    assign tuse[0] = d_rs_tuse;
    assign tuse[1] = d_rt_tuse;

    // One hazard term per source operand; $0 never creates a dependency.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_hz
            assign hz_reg_src[gi] = (src[gi] != 5'd0) &&
                                    (((src[gi] == e_wa) && (tuse[gi] < e_tnew)) ||
                                     ((src[gi] == m_wa) && (tuse[gi] < m_tnew)));
        end
    endgenerate

    assign start_valid = (e_md_start == 2'b01) || (e_md_start == 2'b10);
    assign busy_int    = (cnt_reg != 6'd0);
    assign done_int    = (cnt_reg == 6'd1);
    assign hz_md       = d_is_md && (busy_int || start_valid);
    assign stall       = hz_reg_src[0] || hz_reg_src[1] || hz_md;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= MD_IDLE;
            cnt_reg   <= 6'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // A start arriving while busy is ignored; a start alongside a flush is squashed.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            MD_IDLE: begin
                if (start_valid && !m_exc_req && !m_eret) begin
                    if (e_md_start == 2'b01) begin
                        state_next = MD_MULT;
                        cnt_next   = 6'(MULT_CYCLES);
                    end else begin
                        state_next = MD_DIV;
                        cnt_next   = 6'(DIV_CYCLES);
                    end
                end
            end
            MD_MULT, MD_DIV: begin
                if (cnt_reg <= 6'd1) begin
                    state_next = MD_IDLE;
                    cnt_next   = 6'd0;
                end else begin
                    cnt_next = cnt_reg - 6'd1;
                end
            end
            default: begin
                state_next = MD_IDLE;
                cnt_next   = 6'd0;
            end
        endcase
    end

    always_comb begin
        freeze_f = 1'b0;
        freeze_d = 1'b0;
        flush_d  = 1'b0;
        flush_e  = 1'b0;
        flush_m  = 1'b0;
        pc_sel   = 2'b00;
        md_busy  = 1'b0;
        md_done  = 1'b0;
        if (reset) begin
            md_busy = busy_int;
            md_done = done_int;
            if (m_exc_req) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                flush_m = 1'b1;
                pc_sel  = 2'b01;
            end else if (m_eret) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
                flush_m = 1'b1;
                pc_sel  = 2'b10;
            end else if (stall) begin
                freeze_f = 1'b1;
                freeze_d = 1'b1;
                flush_e  = 1'b1;
            end
        end
    end

endmodule
